switch_key_input: RTL and testbench
===================================

// Module: switch_key_input
// PURPOSE
//  Bus-mapped user-input peripheral: the input-side counterpart of the bus-mapped digital tube display.
//  Synchronises and debounces 64 DIP-switch bits and 8 push keys.
//  Presents them to the CPU as readable registers, latches key-press events and raises an interrupt request.
//  Sits on the CPU bridge beside the display and timer; 3-bit word address, combinational read data.
// PARAMETERS
//  TICK_DIV      2500  clk cycles per debounce sample tick (>=2)
//  STABLE_TICKS  4     consecutive identical samples required before committing new input value (>=1)
// PORTS
//  clk         in   1   system clock, single clock domain
//  reset       in   1   synchronous, active-high reset
//  we          in   1   bus write enable
//  addr        in   3   bus word address
//  din         in   32  bus write data
//  dout        out  32  bus read data (combinational on addr)
//  dip_switch  in   64  raw DIP switches, active-low, asynchronous
//  user_key    in   8   raw push keys, active-low, asynchronous
//  irq         out  1   interrupt request, level, active-high
// BEHAVIOUR
//  Input path: raw = ~{user_key, dip_switch} (72 bits, active-high). Two-flop synchroniser -> sync.
//  Tick: div counts 0..TICK_DIV-1 and wraps; tick=1 for the one cycle where div==TICK_DIV-1.
//  Debounce, evaluated only on tick:
//    if sync != samp: samp<=sync, cnt<=1.
//    else if cnt<STABLE_TICKS: cnt<=cnt+1.
//    when cnt+1==STABLE_TICKS (or STABLE_TICKS==1), also stab<=sync on that same tick.
//  Effect: stab updates only after the whole 72-bit vector is unchanged for STABLE_TICKS ticks.
//    Any bit change restarts the count; cnt saturates at STABLE_TICKS.
//  Key events: on a cycle where stab key bit i goes 0->1, pend[i]<=1. Releases generate no event.
//  Register map (read: dout; write: we=1 on posedge clk):
//    0: R  stab[31:0]      (switches 31..0)
//    1: R  stab[63:32]     (switches 63..32)
//    2: R  {24'b0, stab[71:64]} (keys)
//    3: RW {24'b0, pend}; write: pend[i] cleared where din[i]=1 (W1C)
//    4: RW {31'b0, ien}; write: ien<=din[0]
//    5-7: R 0; writes ignored. Writes to 0-2 ignored.
//  Same-cycle W1C clear and new press on the same bit: set wins, pend[i]=1.
//  irq = ien & |pend, combinational from registers; no extra latency.
//  Reads have no side effects. dout is valid in the same cycle as addr.
//  Latency: a clean raw change reaches stab 2 sync cycles + up to STABLE_TICKS ticks later.
//    Range 2+(STABLE_TICKS-1)*TICK_DIV+1 .. 2+STABLE_TICKS*TICK_DIV cycles.
//  Reset values: sync=0, samp=0, stab=0, cnt=0, div=0, pend=0, ien=0.
//    Resulting outputs: dout = 0 for every addr, irq=0.
//  Reset mid-operation: all state cleared; a key held through reset is seen as a fresh press
//    once debounced, and sets pend.
//  Bounce: a bit toggling at intervals shorter than STABLE_TICKS ticks never commits;
//    stab keeps its prior value.
// TESTING (bench uses TICK_DIV=4, STABLE_TICKS=3)
//  1 reset asserted 2 cycles, inputs all released (all 1s)
//    -> dout=0 at addr 0..7, irq=0, stays so for 100 cycles.
//  2 dip_switch=~64'h0000_00FF_1234_5678
//    -> addr0 reads 12345678h and addr1 reads 000000FFh, within 2+12 cycles and not before 2+8.
//  3 user_key[2] low and bouncing every 5 cycles for 40 cycles, then held low
//    -> addr2 stays 0 during bounce, then reads 04h; pend=04h once.
//  4 ien=1 (write 1 to addr4), press key0
//    -> irq=1; write 01h to addr3 -> irq=0 next cycle; release key0 -> no new pend.
//  5 W1C write 02h to addr3 on the exact cycle key1 commits a press
//    -> pend[1]=1 after the edge, irq=1.
//  6 key7 held low, reset pulsed mid-run
//    -> pend=0 after reset, then pend=80h after debounce; write to addr0/addr6 -> no register change.

Source files
------------

// File: rtl/switch_key_input.sv
// -----------------------------------------------------------------------------
// switch_key_input
//
// Bus-mapped user-input peripheral. It takes 64 DIP switches and 8 push keys,
// synchronises and debounces them, and presents the debounced values to the
// CPU as read-only registers. It also latches key-press events into a pending
// register and raises a level interrupt when enabled.
//
// Raw inputs are active-low. Internally every bit is active-high: 1 means the
// switch is on or the key is pressed.
//
// Ports
//   clk         system clock (single domain)
//   reset       synchronous, active-high reset
//   we          bus write enable, sampled on posedge clk
//   addr[2:0]   bus word address
//   din[31:0]   bus write data
//   dout[31:0]  bus read data, combinational on addr
//   dip_switch  raw DIP switches, active-low, asynchronous
//   user_key    raw push keys, active-low, asynchronous
//   irq         interrupt request, level, active-high
//
// Register map
//   0 R   debounced switches 31..0
//   1 R   debounced switches 63..32
//   2 R   {24'b0, debounced keys}
//   3 RW  {24'b0, pend}, write-1-to-clear
//   4 RW  {31'b0, ien}
//   5-7   read as zero
//
// Writes to addresses 0-2 and 5-7 are ignored.
// -----------------------------------------------------------------------------
module switch_key_input #(
   parameter int TICK_DIV     = 2500,  // clk cycles per debounce sample (>=2)
   parameter int STABLE_TICKS = 4      // identical samples needed to commit (>=1)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [2:0]  addr,
   input  logic [31:0] din,
   output logic [31:0] dout,
   input  logic [63:0] dip_switch,
   input  logic [7:0]  user_key,
   output logic        irq
);

   localparam int DIV_W = $clog2(TICK_DIV);
   localparam int CNT_W = $clog2(STABLE_TICKS + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_TICKS);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // Active-high view of all 72 inputs: keys occupy bits 71..64.
   logic [71:0] raw;
   assign raw = ~{user_key, dip_switch};

   logic [71:0]      meta_q;
   logic [71:0]      sync_q;
   logic [71:0]      samp_q, samp_d;
   logic [71:0]      stab_q, stab_d;
   logic [CNT_W-1:0] cnt_q,  cnt_d;
   logic [DIV_W-1:0] div_q,  div_d;
   logic [7:0]       pend_q, pend_d;
   logic             ien_q,  ien_d;
   logic             tick;
   logic [7:0]       key_rise;
   logic [7:0]       pend_clr;

   // Only the low bits of din have meaning; the rest are deliberately ignored.
   logic unused_din_bits;
   assign unused_din_bits = ^din[31:8];

   // --------------------------------------------------------------------------
   // Sample-tick divider
   // --------------------------------------------------------------------------
   assign tick  = (div_q == DIV_LAST);
   assign div_d = tick ? '0 : div_q + 1'b1;

   // --------------------------------------------------------------------------
   // Debounce
   //
   // The whole 72-bit vector is treated as one sample. Any change restarts the
   // stability count, so stab only moves after every bit has been quiet for
   // STABLE_TICKS consecutive samples. cnt saturates at STABLE_TICKS, which
   // means a settled input costs no further activity.
   // --------------------------------------------------------------------------
   always_comb begin
      samp_d = samp_q;
      cnt_d  = cnt_q;
      stab_d = stab_q;
      if (tick) begin
         if (sync_q != samp_q) begin
            samp_d = sync_q;
            cnt_d  = CNT_ONE;
            // With a single-sample requirement the first new sample commits.
            if (STABLE_TICKS == 1) begin
               stab_d = sync_q;
            end
         end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q + 1'b1 == CNT_MAX) begin
               stab_d = sync_q;
            end
         end
      end
   end

   // --------------------------------------------------------------------------
   // Key events and control registers
   //
   // A press is detected on the same edge that commits it to stab. If a
   // write-1-to-clear hits the same bit on that edge, the set takes priority so
   // the event is never lost.
   // --------------------------------------------------------------------------
   assign pend_clr = (we && addr == 3'd3) ? din[7:0] : 8'h00;

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_key
         assign key_rise[gi] = stab_d[64+gi] & ~stab_q[64+gi];
         assign pend_d[gi]   = key_rise[gi] | (pend_q[gi] & ~pend_clr[gi]);
      end
   endgenerate

   assign ien_d = (we && addr == 3'd4) ? din[0] : ien_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= '0;
         sync_q <= '0;
         samp_q <= '0;
         stab_q <= '0;
         cnt_q  <= '0;
         div_q  <= '0;
         pend_q <= '0;
         ien_q  <= 1'b0;
      end else begin
         meta_q <= raw;
         sync_q <= meta_q;
         samp_q <= samp_d;
         stab_q <= stab_d;
         cnt_q  <= cnt_d;
         div_q  <= div_d;
         pend_q <= pend_d;
         ien_q  <= ien_d;
      end
   end

   // --------------------------------------------------------------------------
   // Read mux and interrupt (both purely combinational from registers)
   // --------------------------------------------------------------------------
   always_comb begin
      dout = 32'h0;
      case (addr)
         3'd0:    dout = stab_q[31:0];
         3'd1:    dout = stab_q[63:32];
         3'd2:    dout = {24'h0, stab_q[71:64]};
         3'd3:    dout = {24'h0, pend_q};
         3'd4:    dout = {31'h0, ien_q};
         default: dout = 32'h0;
      endcase
   end

   assign irq = ien_q & (|pend_q);

endmodule

// File: tb/tb_switch_key_input.sv
module tb_switch_key_input;

   localparam int TD      = 4;
   localparam int ST      = 3;
   localparam int SEL_IRQ = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        we;
   logic [2:0]  addr;
   logic [31:0] din;
   logic [31:0] dout;
   logic [63:0] dip_switch;
   logic [7:0]  user_key;
   logic        irq;

   int n_cmp = 0;
   int n_mis = 0;
   int tb_div = 0;
   int c;

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] exp;
   } exp_t;

   exp_t sb_q[$];

   always #50 clk = ~clk;

   switch_key_input #(.TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
      .clk        (clk),
      .reset      (reset),
      .we         (we),
      .addr       (addr),
      .din        (din),
      .dout       (dout),
      .dip_switch (dip_switch),
      .user_key   (user_key),
      .irq        (irq)
   );

   // Phase of the sample divider; tb_div==0 just after an edge means that edge
   // was a sample tick.
   always @(posedge clk) begin
      if (reset) tb_div <= 0;
      else       tb_div <= (tb_div == TD - 1) ? 0 : tb_div + 1;
   end

   task automatic sb_push(input string tag, input int sel, input logic [31:0] exp);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = exp;
      sb_q.push_back(e);
   endtask

   task automatic sb_check();
      exp_t e;
      logic [31:0] obs;
      n_cmp++;
      if (sb_q.size() == 0) begin
         n_mis++;
         $error("FAIL scoreboard: observed empty queue, expected an entry");
         return;
      end
      e = sb_q.pop_front();
      if (e.sel == SEL_IRQ) begin
         #1;
         obs = {31'b0, irq};
      end else begin
         addr = e.sel[2:0];
         #1;
         obs = dout;
      end
      assert (obs === e.exp)
      else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
      $display("check %s sel=%0d observed=%h expected=%h", e.tag, e.sel, obs, e.exp);
   endtask

   task automatic chk(input string tag, input int sel, input logic [31:0] exp);
      sb_push(tag, sel, exp);
      sb_check();
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      addr = a;
      din  = d;
      we   = 1'b1;
      @(posedge clk);
      #1;
      we   = 1'b0;
      din  = 32'h0;
      $display("write addr=%0d data=%h", a, d);
   endtask

   task automatic wait_val(input int sel, input logic [31:0] val, input int max_cyc,
                           output int cyc);
      cyc = -1;
      for (int i = 1; i <= max_cyc; i++) begin
         @(posedge clk);
         #1;
         addr = sel[2:0];
         #1;
         if (dout === val) begin
            cyc = i;
            break;
         end
      end
   endtask

   task automatic wait_tick();
      do begin
         @(posedge clk);
         #1;
      end while (tb_div != 0);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset      = 1'b1;
      we         = 1'b0;
      addr       = 3'd0;
      din        = 32'h0;
      dip_switch = '1;
      user_key   = '1;

      // 1: reset and idle state
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      for (int a = 0; a < 8; a++) chk("t1_reset_reg", a, 32'h0);
      chk("t1_reset_irq", SEL_IRQ, 32'h0);
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         chk("t1_idle_reg", i % 8, 32'h0);
         chk("t1_idle_irq", SEL_IRQ, 32'h0);
      end

      // 2: switch pattern and debounce latency
      @(posedge clk);
      #1;
      dip_switch = ~64'h0000_00FF_1234_5678;
      sb_push("t2_addr0", 0, 32'h1234_5678);
      sb_push("t2_addr1", 1, 32'h0000_00FF);
      sb_push("t2_keys", 2, 32'h0);
      sb_push("t2_pend", 3, 32'h0);
      wait_val(0, 32'h1234_5678, 20, c);
      n_cmp++;
      assert (c >= 2 + (ST - 1) * TD + 1 && c <= 2 + ST * TD)
      else begin
         n_mis++;
         $error("FAIL t2_latency: observed %0d cycles expected 11..14", c);
      end
      $display("check t2_latency observed=%0d", c);
      repeat (4) sb_check();

      // 3: bouncing key2 never commits, then a held press does
      @(posedge clk);
      #1;
      user_key[2] = 1'b0;
      for (int k = 0; k < 8; k++) begin
         for (int j = 0; j < 5; j++) begin
            @(posedge clk);
            #1;
            chk("t3_bounce_keys", 2, 32'h0);
         end
         user_key[2] = ~user_key[2];
      end
      wait_val(2, 32'h04, 20, c);
      chk("t3_keys", 2, 32'h04);
      chk("t3_pend", 3, 32'h04);
      chk("t3_irq_disabled", SEL_IRQ, 32'h0);
      idle(20);
      chk("t3_pend_once", 3, 32'h04);
      wr(3'd3, 32'h04);
      chk("t3_pend_cleared", 3, 32'h0);

      // 4: interrupt enable, press, clear, release
      wr(3'd4, 32'h1);
      chk("t4_ien", 4, 32'h1);
      chk("t4_irq_idle", SEL_IRQ, 32'h0);
      user_key[0] = 1'b0;
      wait_val(3, 32'h01, 20, c);
      chk("t4_pend", 3, 32'h01);
      chk("t4_irq_set", SEL_IRQ, 32'h1);
      wr(3'd3, 32'h01);
      chk("t4_irq_cleared", SEL_IRQ, 32'h0);
      user_key[0] = 1'b1;
      idle(20);
      chk("t4_release_pend", 3, 32'h0);
      chk("t4_release_irq", SEL_IRQ, 32'h0);
      chk("t4_release_keys", 2, 32'h04);

      // 5: clear and new press on the same edge -- set wins
      wait_tick();
      user_key[1] = 1'b0;
      idle(11);
      chk("t5_precommit_keys", 2, 32'h04);
      wr(3'd3, 32'h02);
      chk("t5_commit_keys", 2, 32'h06);
      chk("t5_pend_set_wins", 3, 32'h02);
      chk("t5_irq", SEL_IRQ, 32'h1);
      wr(3'd3, 32'h02);
      chk("t5_pend_cleared", 3, 32'h0);
      chk("t5_irq_cleared", SEL_IRQ, 32'h0);

      // 6: key held through a mid-run reset
      user_key[1] = 1'b1;
      user_key[2] = 1'b1;
      idle(20);
      wr(3'd3, 32'hFF);
      user_key[7] = 1'b0;
      wait_val(3, 32'h80, 20, c);
      chk("t6_pend_before_reset", 3, 32'h80);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("t6_reset_pend", 3, 32'h0);
      chk("t6_reset_ien", 4, 32'h0);
      chk("t6_reset_addr0", 0, 32'h0);
      chk("t6_reset_irq", SEL_IRQ, 32'h0);
      wait_val(3, 32'h80, 30, c);
      chk("t6_pend_after", 3, 32'h80);
      chk("t6_irq_ien_off", SEL_IRQ, 32'h0);
      wr(3'd0, 32'hFFFF_FFFF);
      wr(3'd6, 32'hFFFF_FFFF);
      chk("t6_addr0_ro", 0, 32'h1234_5678);
      chk("t6_addr1_ro", 1, 32'h0000_00FF);
      chk("t6_addr6_zero", 6, 32'h0);
      chk("t6_keys", 2, 32'h80);
      chk("t6_pend_kept", 3, 32'h80);
      chk("t6_ien_kept", 4, 32'h0);
      wr(3'd4, 32'h1);
      chk("t6_irq_enabled", SEL_IRQ, 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
